// File: rtl/wave_synth_low.sv
// Triangle-wave sample generator centred on the low-band analyzer midline.
// Define WSYN_SQUARE_EN to add the shape input that selects a square wave.
module wave_synth_low #(
  parameter logic [15:0] MID        = 16'd567,
  parameter int          FRAC       = 10,
  parameter logic [21:0] MIN_PERIOD = 22'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [21:0] cfg_period,
  input  logic [11:0] cfg_amp,
`ifdef WSYN_SQUARE_EN
  input  logic        shape,
`endif
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        cyc_start
);
  localparam int LW = 12 + FRAC;
  localparam int CW = $clog2(LW);
  localparam logic [CW-1:0] LAST_ITER = CW'(LW - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_RUN} state_t;
  typedef logic [LW:0] wide_t;

  state_t        state_q, state_d;
  logic [21:0]   period_q, period_d;
  logic [11:0]   amp_q, amp_d;
  logic [LW-1:0] step_q, step_d;
  logic [21:0]   ph_q, ph_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [21:0]   pend_period_q, pend_period_d;
  logic [11:0]   pend_amp_q, pend_amp_d;
`ifdef WSYN_SQUARE_EN
  logic          shape_q, shape_d;
  logic          pend_shape_q, pend_shape_d;
  logic          ld_shape;
`endif
  logic [15:0]   sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;
  logic          cyc_start_q, cyc_start_d;
  logic          cfg_ready_q, cfg_ready_d;

  logic          accept, load, at_wrap, rising;
  logic [21:0]   cfg_period_c, half_c, ld_period;
  logic [11:0]   ld_amp;
  wide_t         rem_sh, up_sum;
  logic [LW-1:0] rem_nx, quo_nx, amp_full, lvl_up, lvl_dn;
  logic [15:0]   base_d, sum_d;

  assign cfg_period_c = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
  assign half_c       = period_q >> 1;
  assign accept       = cfg_valid && cfg_ready_q && en;
  assign at_wrap      = (ph_q == period_q - 22'd1);
  assign rising       = (ph_q < half_c);

  // One restoring-division step per DIVIDE cycle; quo_q shifts dividend out, quotient in.
  assign rem_sh = {rem_q, quo_q[LW-1]};
  always_comb begin
    if (rem_sh >= wide_t'(half_c)) begin
      rem_nx = rem_sh[LW-1:0] - LW'(half_c);
      quo_nx = {quo_q[LW-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[LW-1:0];
      quo_nx = {quo_q[LW-2:0], 1'b0};
    end
  end

  assign amp_full = {amp_q, {FRAC{1'b0}}};
  assign up_sum   = {1'b0, lvl_q} + {1'b0, step_q};
  assign lvl_up   = (up_sum > {1'b0, amp_full}) ? amp_full : up_sum[LW-1:0];
  assign lvl_dn   = (lvl_q < step_q) ? '0 : lvl_q - step_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      period_q       <= MIN_PERIOD;
      amp_q          <= '0;
      step_q         <= '0;
      ph_q           <= '0;
      lvl_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      pend_period_q  <= MIN_PERIOD;
      pend_amp_q     <= '0;
`ifdef WSYN_SQUARE_EN
      shape_q        <= 1'b0;
      pend_shape_q   <= 1'b0;
`endif
      sample_q       <= MID;
      sample_valid_q <= 1'b0;
      cyc_start_q    <= 1'b0;
      cfg_ready_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      amp_q          <= amp_d;
      step_q         <= step_d;
      ph_q           <= ph_d;
      lvl_q          <= lvl_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      cnt_q          <= cnt_d;
      pend_q         <= pend_d;
      pend_period_q  <= pend_period_d;
      pend_amp_q     <= pend_amp_d;
`ifdef WSYN_SQUARE_EN
      shape_q        <= shape_d;
      pend_shape_q   <= pend_shape_d;
`endif
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      cyc_start_q    <= cyc_start_d;
      cfg_ready_q    <= cfg_ready_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    amp_d         = amp_q;
    step_d        = step_q;
    ph_d          = ph_q;
    lvl_d         = lvl_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    pend_period_d = pend_period_q;
    pend_amp_d    = pend_amp_q;
    load          = 1'b0;
    ld_period     = cfg_period_c;
    ld_amp        = cfg_amp;
`ifdef WSYN_SQUARE_EN
    shape_d       = shape_q;
    pend_shape_d  = pend_shape_q;
    ld_shape      = shape;
`endif
    if (!en) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      ph_d    = '0;
      lvl_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: load = accept;
        S_DIVIDE: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_RUN;
            step_d  = quo_nx;
            ph_d    = '0;
            lvl_d   = '0;
          end
        end
        S_RUN: begin
          if (at_wrap) begin
            // Forcing lvl to 0 every period keeps rounding error from accumulating.
            ph_d  = '0;
            lvl_d = '0;
            if (pend_q) begin
              load      = 1'b1;
              ld_period = pend_period_q;
              ld_amp    = pend_amp_q;
`ifdef WSYN_SQUARE_EN
              ld_shape  = pend_shape_q;
`endif
              pend_d    = 1'b0;
            end else begin
              load = accept;
            end
          end else begin
            ph_d  = ph_q + 22'd1;
            lvl_d = rising ? lvl_up : lvl_dn;
            if (accept) begin
              pend_d        = 1'b1;
              pend_period_d = cfg_period_c;
              pend_amp_d    = cfg_amp;
`ifdef WSYN_SQUARE_EN
              pend_shape_d  = shape;
`endif
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (load) begin
      state_d  = S_DIVIDE;
      period_d = ld_period;
      amp_d    = ld_amp;
      quo_d    = {ld_amp, {FRAC{1'b0}}};
      rem_d    = '0;
      cnt_d    = '0;
`ifdef WSYN_SQUARE_EN
      shape_d  = ld_shape;
`endif
    end
  end

  // Outputs are derived from next-state values so they line up with the registered state.
  always_comb begin
    sample_d       = MID;
    sample_valid_d = 1'b0;
    cyc_start_d    = 1'b0;
    cfg_ready_d    = 1'b0;
    base_d         = MID - {5'd0, amp_d[11:1]};
    sum_d          = base_d + {4'd0, lvl_d[FRAC+11:FRAC]};
`ifdef WSYN_SQUARE_EN
    if (shape_d) begin
      sum_d = (ph_d < (period_d >> 1)) ? base_d + {4'd0, amp_d} : base_d;
    end
`endif
    case (state_d)
      S_IDLE: cfg_ready_d = 1'b1;
      S_RUN: begin
        sample_valid_d = 1'b1;
        cyc_start_d    = (ph_d == '0);
        cfg_ready_d    = !pend_d;
        sample_d       = sum_d;
      end
      default: cfg_ready_d = 1'b0;
    endcase
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign cyc_start    = cyc_start_q;
  assign cfg_ready    = cfg_ready_q;
endmodule

// File: tb/tb_wave_synth_low.sv
// Scoreboard bench for wave_synth_low: directed configs push hand-computed samples,
// a negedge monitor pops and compares every valid sample.
module tb_wave_synth_low;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [21:0] cfg_period = '0;
  logic [11:0] cfg_amp = '0;
`ifdef WSYN_SQUARE_EN
  logic        shape = 1'b0;
`endif
  logic        cfg_ready;
  logic [15:0] sample;
  logic        sample_valid;
  logic        cyc_start;

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];

  // Rows: 0 tri p8 a800, 1 tri p16 a400, 2 flat p4 a0, 3 tri p9 a800
  int tbl [4][16] = '{
    '{167, 367, 567, 767, 967, 767, 567, 367, 0, 0, 0, 0, 0, 0, 0, 0},
    '{367, 417, 467, 517, 567, 617, 667, 717, 767, 717, 667, 617, 567, 517, 467, 417},
    '{567, 567, 567, 567, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{167, 367, 567, 767, 967, 767, 567, 367, 167, 0, 0, 0, 0, 0, 0, 0}
  };

  always #5 clk = ~clk;

  wave_synth_low dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_amp      (cfg_amp),
`ifdef WSYN_SQUARE_EN
    .shape        (shape),
`endif
    .sample       (sample),
    .sample_valid (sample_valid),
    .cyc_start    (cyc_start)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wave(input int idx, input int len, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      exp_q.push_back({((i % len) == 0), 16'(tbl[idx][i % len])});
    end
  endtask

  task automatic issue(input int per, input int amp);
    $display("config period=%0d amp=%0d at t=%0t", per, amp, $time);
    cfg_valid  = 1'b1;
    cfg_period = 22'(per);
    cfg_amp    = 12'(amp);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    @(negedge clk);
    check("ready_in_divide", cfg_ready, 0);
    while (!sample_valid && n < 60) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic play(input int idx, input int len, input int per, input int amp, input int nper);
    int n;
    push_wave(idx, len, len * nper);
    check("ready_idle", cfg_ready, 1);
    issue(per, amp);
    wait_run(n);
    check("divide_len", n, 22);
    repeat (len * nper - 1) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stop_valid", sample_valid, 0);
    check("stop_ready", cfg_ready, 1);
    @(posedge clk);
    #1 en = 1'b1;
  endtask

  // Monitor: every valid sample is matched against the scoreboard head.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sample_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_sample: got %0d, expected no valid output", sample);
          end else begin
            e = exp_q.pop_front();
            check("sample", sample, e[15:0]);
            check("cyc_start", cyc_start, e[16]);
          end
        end else begin
          check("idle_sample", sample, 567);
          check("idle_cyc_start", cyc_start, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int k;
    int v;
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_sample", sample, 567);
    check("rst_valid", sample_valid, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_cyc_start", cyc_start, 0);
    @(posedge clk);
    #1 en = 1'b1;

    // Basic triangle, then reconfigure at ph=3
    push_wave(0, 8, 8);
    check("ready_idle", cfg_ready, 1);
    issue(8, 800);
    wait_run(n);
    check("divide_len", n, 22);
    repeat (3) @(posedge clk);
    #1;
    check("ready_run", cfg_ready, 1);
    push_wave(1, 16, 6);
    issue(16, 400);
    @(negedge clk);
    check("ready_pending", cfg_ready, 0);
    k = 0;
    while (sample_valid && k < 20) begin
      k++;
      @(negedge clk);
    end
    check("old_wave_tail", k, 4);
    n = 0;
    while (!sample_valid && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("reconfig_divide_len", n, 22);

    // Accept a pending config at ph=2, then drop en at ph=5
    repeat (2) @(posedge clk);
    #1;
    check("ready_run2", cfg_ready, 1);
    issue(8, 800);
    @(negedge clk);
    check("ready_pending2", cfg_ready, 0);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_sample", sample, 567);
    check("dis_valid", sample_valid, 0);
    check("dis_ready", cfg_ready, 1);
    @(posedge clk);
    #1 en = 1'b1;
    v = 0;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) v++;
    end
    check("pending_dropped", v, 0);
    @(posedge clk);
    #1;

    // Clamps: short period with zero amplitude, odd period
    play(2, 4, 2, 0, 3);
    play(3, 9, 9, 800, 2);

    // Reset during divide iteration 10, then a fresh config
    issue(8, 800);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_sample", sample, 567);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_ready", cfg_ready, 1);
    check("mid_rst_cyc_start", cyc_start, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    play(0, 8, 8, 800, 2);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
